// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered reset-domain release with soft reset and optional watchdog
//
// Purpose:
//   Resynchronises the board reset (asynchronous assert, synchronous release),
//   then releases STAGES reset domains one at a time, bit 0 first, STAGE_GAP
//   cycles apart. Software can request a full re-sequence through a
//   soft_req/soft_ack handshake.
//   Defining WATCHDOG_EN adds a watchdog that re-sequences the domains when it
//   is not kicked for WDT_CYCLES RUN cycles. Without WATCHDOG_EN no watchdog
//   logic is built and wdt_fired is tied low.
//
// Ports:
//   CLK        design clock
//   RESET      asynchronous active-low reset
//   soft_req   soft-reset request level, held by the requester until soft_ack
//   wdt_kick   watchdog restart pulse (ignored without WATCHDOG_EN)
//   rst_n      per-domain active-low resets, bit 0 released first
//   ready      all domains released and sequencer in RUN
//   stage      number of domains currently released
//   soft_ack   one-cycle acknowledge of soft_req
//   wdt_fired  sticky flag, watchdog caused a reset (cleared only by RESET)
module reset_sequencer #(
  parameter int STAGES     = 3,
  parameter int STAGE_GAP  = 16,
  parameter int SYNC_DEPTH = 2,
  parameter int SOFT_HOLD  = 8,
  parameter int WDT_CYCLES = 65536
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        soft_req,
  input  logic                        wdt_kick,
  output logic [STAGES-1:0]           rst_n,
  output logic                        ready,
  output logic [$clog2(STAGES+1)-1:0] stage,
  output logic                        soft_ack,
  output logic                        wdt_fired
);

  localparam int STAGE_W = $clog2(STAGES + 1);
  // One counter serves both the release gap and the soft hold time.
  localparam int CNT_MAX = ((STAGE_GAP > SOFT_HOLD) ? STAGE_GAP : SOFT_HOLD) - 1;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(SOFT_HOLD - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [STAGE_W-1:0] STAGE_ALL = STAGE_W'(STAGES);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN,
    ST_SOFT
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [STAGES-1:0]    rst_n_q, rst_n_d;
  logic                 ready_q, ready_d;
  logic                 soft_ack_q, soft_ack_d;
  logic                 sync_rel;
  logic                 wdt_expired;

  // Release synchroniser: shifts in ones once RESET deasserts.
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], 1'b1};
  end

  assign sync_rel = sync_q[SYNC_DEPTH-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    ready_d    = 1'b0;
    soft_ack_d = 1'b0;
    rst_n_d    = '0;
    cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ST_HOLD: begin
        stage_d = '0;
        // Gap counting starts on the first edge after the synchroniser
        // output (or the SOFT exit) has gone high.
        if (sync_rel) begin
          if (cnt_q == GAP_LAST) begin
            stage_d = STAGE_W'(1);
            cnt_d   = '0;
            state_d = ST_RELEASE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_RELEASE: begin
        if (stage_q == STAGE_ALL) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          stage_d = stage_q + STAGE_W'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
        // A watchdog expiry takes the same path as a soft reset but without
        // the acknowledge; a coincident soft_req still gets its ack.
        if (soft_req || wdt_expired) begin
          state_d    = ST_SOFT;
          stage_d    = '0;
          ready_d    = 1'b0;
          cnt_d      = '0;
          soft_ack_d = soft_req;
        end
      end
      ST_SOFT: begin
        stage_d = '0;
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_HOLD;
        stage_d = '0;
        cnt_d   = '0;
      end
    endcase

    // Thermometer decode of the released-domain count.
    for (int i = 0; i < STAGES; i++) begin
      rst_n_d[i] = (stage_d > STAGE_W'(i));
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q     <= '0;
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      stage_q    <= '0;
      rst_n_q    <= '0;
      ready_q    <= 1'b0;
      soft_ack_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      rst_n_q    <= rst_n_d;
      ready_q    <= ready_d;
      soft_ack_q <= soft_ack_d;
    end
  end

`ifdef WATCHDOG_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             wdt_fired_q, wdt_fired_d;

  assign wdt_expired = (state_q == ST_RUN) && (wdt_cnt_q == WDT_LAST);

  always_comb begin
    wdt_cnt_d   = wdt_cnt_q;
    wdt_fired_d = wdt_fired_q;
    if (state_q != ST_RUN) begin
      // Idle outside RUN; restart from zero on RUN entry.
      if (state_d == ST_RUN) begin
        wdt_cnt_d = '0;
      end
    end else if (wdt_kick) begin
      wdt_cnt_d = '0;
    end else if (wdt_cnt_q != WDT_LAST) begin
      wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
    end
    if (wdt_expired && !soft_req) begin
      wdt_fired_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wdt_cnt_q   <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fired_q <= wdt_fired_d;
    end
  end

  assign wdt_fired = wdt_fired_q;
`else
  logic wdt_kick_unused;

  assign wdt_kick_unused = wdt_kick;
  assign wdt_expired     = 1'b0;
  assign wdt_fired       = 1'b0;
`endif

  assign rst_n    = rst_n_q;
  assign ready    = ready_q;
  assign stage    = stage_q;
  assign soft_ack = soft_ack_q;

endmodule
